prach_hb1_sched: RTL

Time-division scheduler that feeds the 3-lane PRACH half-band decimator (HB1) from NUM_CH upstream antenna-carrier channels. Each frame of FRAME_LEN clock cycles grants every requesting channel at most one issue slot, in round-robin order. On a granted slot it forwards that channel's sample pair (dp1/dp2, three lanes) with valid, channel number and a frame sync. It sits between the per-channel upstream buffers and prach_hb1, and is the only source of that filter's din_* and sync_in inputs.

---
 rtl/prach_hb1_sched_if.sv | 29 ++
 rtl/prach_hb1_sched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/prach_hb1_sched_if.sv
// Bus bundle between the per-channel upstream buffers, the HB1 scheduler and prach_hb1.
// The scheduler uses the master side; the upstream/filter environment uses the slave side.
interface prach_hb1_sched_if #(
  parameter int NUM_CH = 12
);
  logic                         en;
  logic [NUM_CH-1:0]            req;
  logic [NUM_CH-1:0][2:0][15:0] in_dp1;
  logic [NUM_CH-1:0][2:0][15:0] in_dp2;
  logic [NUM_CH-1:0]            grant;
  logic [2:0][15:0]             hb_dp1;
  logic [2:0][15:0]             hb_dp2;
  logic                         hb_dv;
  logic [7:0]                   hb_chn;
  logic                         hb_sync;
  logic [NUM_CH-1:0]            ovf;
  logic                         ovf_clr;
  logic                         busy;

  modport master (
    input  en, req, in_dp1, in_dp2, ovf_clr,
    output grant, hb_dp1, hb_dp2, hb_dv, hb_chn, hb_sync, ovf, busy
  );

  modport slave (
    output en, req, in_dp1, in_dp2, ovf_clr,
    input  grant, hb_dp1, hb_dp2, hb_dv, hb_chn, hb_sync, ovf, busy
  );
endinterface

// File: rtl/prach_hb1_sched.sv
// TDM round-robin scheduler feeding the 3-lane PRACH HB1 decimator: one issue slot per
// requesting channel per frame, registered sample/valid/channel/sync outputs, sticky overruns.
module prach_hb1_sched #(
  parameter int NUM_CH    = 12,
  parameter int FRAME_LEN = 16
) (
  input logic                 clk,
  input logic                 rst,
  prach_hb1_sched_if.master   bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] served_q, served_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [2:0][15:0]  hb_dp1_q, hb_dp1_d;
  logic [2:0][15:0]  hb_dp2_q, hb_dp2_d;
  logic              hb_dv_q, hb_dv_d;
  logic [7:0]        hb_chn_q, hb_chn_d;
  logic              hb_sync_q, hb_sync_d;
  logic              busy_q, busy_d;

  logic              active;
  logic              frame_start;
  logic              frame_end;
  logic [NUM_CH-1:0] served_eff;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] ovf_set;
  logic              found;
  logic [PTR_W-1:0]  sel;
  int unsigned       scan_idx;

  assign active      = (state_q != IDLE);
  assign frame_start = (cnt_q == '0);
  assign frame_end   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.en) state_d = RUN;
      end
      RUN: begin
        cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);
        if (!bus.en) state_d = STOP;
      end
      STOP: begin
        cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);
        if (bus.en)         state_d = RUN;
        else if (frame_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The served mask is logically empty in the first slot of every frame.
  always_comb begin
    served_eff = frame_start ? '0 : served_q;
    eligible   = active ? (bus.req & ~served_eff) : '0;
    found      = 1'b0;
    sel        = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!found && eligible[PTR_W'(scan_idx)]) begin
        found = 1'b1;
        sel   = PTR_W'(scan_idx);
      end
    end
    grant = '0;
    if (found) grant[sel] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) rr_ptr_d = (sel == PTR_LAST) ? '0 : sel + PTR_W'(1);
    served_d = active ? (served_eff | grant) : '0;
    ovf_set  = (active && frame_end) ? (bus.req & ~served_eff & ~grant) : '0;
    ovf_d    = (bus.ovf_clr ? '0 : ovf_q) | ovf_set;
    hb_dv_d  = found;
    hb_dp1_d = found ? bus.in_dp1[sel] : hb_dp1_q;
    hb_dp2_d = found ? bus.in_dp2[sel] : hb_dp2_q;
    hb_chn_d = found ? 8'(sel) : hb_chn_q;
    hb_sync_d = active && frame_start;
    busy_d    = active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      served_q  <= '0;
      ovf_q     <= '0;
      hb_dp1_q  <= '0;
      hb_dp2_q  <= '0;
      hb_dv_q   <= 1'b0;
      hb_chn_q  <= '0;
      hb_sync_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      served_q  <= served_d;
      ovf_q     <= ovf_d;
      hb_dp1_q  <= hb_dp1_d;
      hb_dp2_q  <= hb_dp2_d;
      hb_dv_q   <= hb_dv_d;
      hb_chn_q  <= hb_chn_d;
      hb_sync_q <= hb_sync_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.grant   = grant;
  assign bus.hb_dp1  = hb_dp1_q;
  assign bus.hb_dp2  = hb_dp2_q;
  assign bus.hb_dv   = hb_dv_q;
  assign bus.hb_chn  = hb_chn_q;
  assign bus.hb_sync = hb_sync_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = busy_q;

endmodule
